// File: rtl/encoder_pkg.sv
// encoder_pkg: FSM states, stage indices and default round count shared by the encoder round scheduler
package encoder_pkg;
   localparam int NUM_STAGES = 5;
   localparam int DEF_NUM_ROUNDS = 24;
   localparam logic [2:0] STG_COLPAR = 3'd0;
   localparam logic [2:0] STG_ROTATE = 3'd1;
   localparam logic [2:0] STG_PERMUTE = 3'd2;
   localparam logic [2:0] STG_REVAL = 3'd3;
   localparam logic [2:0] STG_ADDRC = 3'd4;
   typedef enum logic [2:0] {IDLE, LAUNCH, ARM, WAIT, FIN} sched_state_t;
endpackage

// File: rtl/encoder_wdt.sv
// encoder_wdt: clearable cycle counter whose terminal flag fires on the LIMIT-th enabled cycle
module encoder_wdt #(
   parameter int LIMIT = 4096
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic term
);
   localparam int W = $clog2(LIMIT + 1);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
   assign term = en && cnt_q == W'(LIMIT - 1);
endmodule

// File: rtl/encoder_round_sched.sv
// encoder_round_sched: runs colpar/rotate/permute/reval/addrc for NUM_ROUNDS rounds via start/ready handshakes.
// Define ENCODER_SCHED_WDT_EN to add a per-stage watchdog that aborts to IDLE with a sticky error.
module encoder_round_sched
   import encoder_pkg::*;
#(
   parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
   parameter int RND_W = 5,
   parameter int WDT_CYCLES = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic [NUM_STAGES-1:0] stage_start,
   input  logic [NUM_STAGES-1:0] stage_ready,
   output logic [RND_W-1:0]      round_idx,
   output logic [2:0]            stage_idx,
   output logic                  mem_sel,
   output logic                  Ready,
   output logic                  done,
   output logic                  error
);
   localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);
   sched_state_t state_q, state_d;
   logic [RND_W-1:0] round_q, round_d;
   logic [2:0] stage_q, stage_d;
   logic mem_q, mem_d, err_q, err_d, act_rdy, wdt_trip, launch;

   assign act_rdy = stage_ready[stage_q];
   assign launch = state_q == LAUNCH;

`ifdef ENCODER_SCHED_WDT_EN
   encoder_wdt #(.LIMIT(WDT_CYCLES)) u_wdt (
      .clk  (clk),
      .reset(reset),
      .clr  (launch),
      .en   (state_q == ARM || state_q == WAIT),
      .term (wdt_trip)
   );
`else
   assign wdt_trip = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      stage_d = stage_q;
      mem_d = mem_q;
      err_d = err_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = LAUNCH;
            round_d = '0;
            stage_d = STG_COLPAR;
            mem_d = 1'b0;
            err_d = 1'b0;
         end
         LAUNCH: state_d = ARM;
         ARM: state_d = act_rdy ? ARM : WAIT;
         WAIT: if (act_rdy) begin
            mem_d = ~mem_q;
            state_d = (stage_q == STG_ADDRC && round_q == LAST_RND) ? FIN : LAUNCH;
            if (stage_q != STG_ADDRC) stage_d = stage_q + 3'd1;
            else if (round_q != LAST_RND) begin
               stage_d = STG_COLPAR;
               round_d = round_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // a watchdog trip freezes the failing position and beats a same-cycle completion
      if (wdt_trip) begin
         state_d = IDLE;
         err_d = 1'b1;
         round_d = round_q;
         stage_d = stage_q;
         mem_d = mem_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         round_q <= '0;
         stage_q <= STG_COLPAR;
         mem_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         stage_q <= stage_d;
         mem_q <= mem_d;
         err_q <= err_d;
      end
   end

   assign stage_start = {NUM_STAGES{launch}} & {stage_q == STG_ADDRC, stage_q == STG_REVAL,
                        stage_q == STG_PERMUTE, stage_q == STG_ROTATE, stage_q == STG_COLPAR};
   assign round_idx = round_q;
   assign stage_idx = stage_q;
   assign mem_sel = mem_q;
   assign Ready = state_q == IDLE;
   assign done = state_q == FIN;
   assign error = err_q;
endmodule

// File: tb/tb_encoder_round_sched.sv
// tb_encoder_round_sched: randomized stage stubs checked every cycle against an operation-level schedule model.
// Build with ENCODER_SCHED_WDT_EN to also exercise the watchdog abort.
module tb_encoder_round_sched;
   localparam int NR = 2;
   localparam int TOT = 5 * NR;
   localparam int WDT = 16;
`ifdef ENCODER_SCHED_WDT_EN
   localparam bit WDT_ON = 1'b1;
`else
   localparam bit WDT_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, start;
   logic [4:0] stage_start, stage_ready, round_idx;
   logic [2:0] stage_idx;
   logic mem_sel, Ready, done, error;
   int checks = 0, errors = 0, cyc = 0;

   encoder_round_sched #(.NUM_ROUNDS(NR), .RND_W(5), .WDT_CYCLES(WDT)) dut (
      .clk(clk), .reset(reset), .start(start), .stage_start(stage_start), .stage_ready(stage_ready),
      .round_idx(round_idx), .stage_idx(stage_idx), .mem_sel(mem_sel), .Ready(Ready), .done(done), .error(error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // stage stubs: after seeing a start, stay high d cycles, low b cycles, then high
   int j[5], d[5], b[5], b_fix[5];
   int hang = -1;
   bit noise = 1'b0, rnd_mode = 1'b0, rs;
   logic [4:0] seen;
   initial begin
      stage_ready = '1;
      for (int i = 0; i < 5; i++) begin
         j[i] = 0; d[i] = 0; b[i] = 0; b_fix[i] = 3;
      end
      forever begin
         @(negedge clk);
         seen = stage_start;
         rs = reset;
         @(posedge clk);
         #1;
         for (int i = 0; i < 5; i++) begin
            if (rs) j[i] = 0;
            else if (seen[i]) begin
               j[i] = 1;
               d[i] = rnd_mode ? int'($urandom_range(0, 2)) : 0;
               b[i] = (i == hang) ? 1000000 : rnd_mode ? int'($urandom_range(1, 5)) : b_fix[i];
            end else if (j[i] > 0) j[i] = (j[i] > d[i] + b[i]) ? 0 : j[i] + 1;
            stage_ready[i] = (j[i] == 0) ? (noise ? 1'($urandom) : 1'b1) : !(j[i] > d[i] && j[i] <= d[i] + b[i]);
         end
      end
   end

   // model: an encode is TOT operations; op n+1 launches the cycle after op n completes,
   // and an op completes in the first high cycle of the active stage after it went low post-launch
   int pos = 0, launch_c = -1, fin_c = -1, ppos;
   bit running = 1'b0, low_seen = 1'b0, err_m = 1'b0;
   int pulses = 0, order_bad = 0, toggles = 0, dones = 0, done_c = -1, rdy_after = 0;
   logic mem_prev = 1'b0, done_prev = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (cyc > 0) begin
            ppos = (pos < TOT) ? pos : TOT - 1;
            chk("stage_start", int'(stage_start), (running && cyc == launch_c) ? (1 << (pos % 5)) : 0);
            chk("Ready", int'(Ready), int'(!running));
            chk("done", int'(done), int'(running && cyc == fin_c));
            chk("round_idx", int'(round_idx), ppos / 5);
            chk("stage_idx", int'(stage_idx), ppos % 5);
            chk("mem_sel", int'(mem_sel), pos % 2);
            chk("error", int'(error), int'(err_m));
            if (|stage_start) begin
               if (stage_start != 5'(1 << (pulses % 5))) order_bad++;
               pulses++;
            end
            if (mem_sel !== mem_prev) toggles++;
            mem_prev = mem_sel;
            if (done_prev) rdy_after = int'(Ready);
            if (done) begin
               dones++;
               done_c = cyc;
            end
            done_prev = done;
         end
         if (reset) begin
            running = 1'b0; pos = 0; launch_c = -1; fin_c = -1; err_m = 1'b0; low_seen = 1'b0;
         end else if (!running) begin
            if (start) begin
               running = 1'b1; pos = 0; launch_c = cyc + 1; fin_c = -1; err_m = 1'b0; low_seen = 1'b0;
            end
         end else if (cyc == fin_c) running = 1'b0;
         else if (cyc > launch_c) begin
            if (WDT_ON && cyc - launch_c == WDT) begin
               err_m = 1'b1;
               running = 1'b0;
            end else if (!low_seen) low_seen = !stage_ready[pos % 5];
            else if (stage_ready[pos % 5]) begin
               pos++;
               low_seen = 1'b0;
               if (pos < TOT) launch_c = cyc + 1;
               else fin_c = cyc + 1;
            end
         end
      end
   end

   int c0;
   initial begin
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", int'(Ready), 1);
      chk("rst_stage_start", int'(stage_start), 0);
      chk("rst_mem_sel", int'(mem_sel), 0);
      chk("rst_error", int'(error), 0);
      // full encode, fixed stub timing: 5 cycles per stage
      @(posedge clk);
      #1 start = 1'b1; c0 = cyc;
      pulses = 0; order_bad = 0; toggles = 0; dones = 0; rdy_after = 0;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (60) @(posedge clk);
      @(negedge clk);
      chk("enc_pulses", pulses, 10);
      chk("enc_order_bad", order_bad, 0);
      chk("enc_toggles", toggles, 10);
      chk("enc_mem_end", int'(mem_sel), 0);
      chk("enc_dones", dones, 1);
      chk("enc_done_latency", done_c - c0, 51);
      chk("enc_ready_after_done", rdy_after, 1);
      // reset in WAIT of round 1, stage 2
      @(posedge clk);
      #1 start = 1'b1; c0 = cyc; dones = 0;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (37) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("pre_rst_stage", int'(stage_idx), 2);
      chk("pre_rst_round", int'(round_idx), 1);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready", int'(Ready), 1);
      chk("mid_rst_round", int'(round_idx), 0);
      chk("mid_rst_stage", int'(stage_idx), 0);
      chk("mid_rst_mem", int'(mem_sel), 0);
      repeat (10) @(posedge clk);
      #1 chk("mid_rst_no_done", dones, 0);
      // idle stages toggle while rotate is held busy for 8 cycles
      noise = 1'b1; b_fix[1] = 8;
      @(posedge clk);
      #1 start = 1'b1; c0 = cyc; dones = 0;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (11) @(posedge clk);
      @(negedge clk);
      chk("wrong_rdy_stage", int'(stage_idx), 1);
      chk("wrong_rdy_mem", int'(mem_sel), 1);
      repeat (70) @(posedge clk);
      #1 noise = 1'b0; b_fix[1] = 3;
      chk("wrong_rdy_dones", dones, 1);
      // start held high across whole encodes with random stub timing
      rnd_mode = 1'b1;
      start = 1'b1;
      repeat (250) @(posedge clk);
      #1 start = 1'b0;
      repeat (100) @(posedge clk);
      // random encodes with occasional mid-run reset
      for (int it = 0; it < 25; it++) begin
         #1 noise = 1'($urandom);
         repeat ($urandom_range(0, 5)) @(posedge clk);
         #1 start = 1'b1;
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #1 start = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(0, 60)) @(posedge clk);
            #1 reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
         end else repeat (100) @(posedge clk);
      end
      #1 noise = 1'b0; rnd_mode = 1'b0;
      repeat (100) @(posedge clk);
`ifdef ENCODER_SCHED_WDT_EN
      // rotate never re-raises Ready: trip after 16 ARM/WAIT cycles
      #1 hang = 1; start = 1'b1; c0 = cyc; dones = 0;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (21) @(posedge clk);
      @(negedge clk);
      chk("wdt_error_before", int'(error), 0);
      @(posedge clk);
      @(negedge clk);
      chk("wdt_error", int'(error), 1);
      chk("wdt_ready", int'(Ready), 1);
      chk("wdt_stage", int'(stage_idx), 1);
      chk("wdt_no_done", dones, 0);
      @(posedge clk);
      #1 hang = -1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("wdt_error_cleared", int'(error), 0);
      repeat (60) @(posedge clk);
      #1 chk("wdt_rerun_dones", dones, 1);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
